// File: rtl/bht_pkg.sv
// bht_pkg
//   Shared types and helpers for the branch history table port scheduler.
//   sched_state_t : scheduler states (init sweep plus update read-modify-write)
//   ctr_t         : 2-bit saturating branch counter
//   ctr_sat()     : one saturating counter step toward the resolved direction
package bht_pkg;

    typedef enum logic [2:0] {
        SCHED_INIT = 3'd0,
        SCHED_IDLE = 3'd1,
        SCHED_RD   = 3'd2,
        SCHED_CAP  = 3'd3,
        SCHED_WR   = 3'd4
    } sched_state_t;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_STK = 2'b11;

    // Counters pin at the strong ends instead of wrapping around.
    function automatic ctr_t ctr_sat(input ctr_t ctr, input logic taken);
        ctr_t res;
        if (taken) begin
            res = (ctr == CTR_STK) ? CTR_STK : ctr + 2'd1;
        end else begin
            res = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bht_port_sched_if.sv
// bht_port_sched_if
//   Bundles the three channels around the scheduler:
//     predict : pred_req/pred_idx in, pred_ready/pred_valid/pred_taken/pred_ctr out
//     resolve : res_valid/res_idx/res_taken in, res_ready out
//     table   : tbl_en/tbl_we/tbl_addr/tbl_wdata out, tbl_rdata in (registered read)
//     status  : init_done out
//   slave  = scheduler view, master = surrounding fetch/execute/table view.
interface bht_port_sched_if #(
    parameter int IDX_W = 2
);
    import bht_pkg::*;

    logic             pred_req;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_ready;
    logic             pred_valid;
    logic             pred_taken;
    ctr_t             pred_ctr;

    logic             res_valid;
    logic [IDX_W-1:0] res_idx;
    logic             res_taken;
    logic             res_ready;

    logic             tbl_en;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    ctr_t             tbl_wdata;
    ctr_t             tbl_rdata;

    logic             init_done;

    modport slave (
        input  pred_req, pred_idx, res_valid, res_idx, res_taken, tbl_rdata,
        output pred_ready, pred_valid, pred_taken, pred_ctr, res_ready,
               tbl_en, tbl_we, tbl_addr, tbl_wdata, init_done
    );

    modport master (
        output pred_req, pred_idx, res_valid, res_idx, res_taken, tbl_rdata,
        input  pred_ready, pred_valid, pred_taken, pred_ctr, res_ready,
               tbl_en, tbl_we, tbl_addr, tbl_wdata, init_done
    );

endinterface

// File: rtl/bht_upd_fifo.sv
// bht_upd_fifo
//   Small FIFO of resolved branch outcomes {idx, taken} waiting to be applied.
//   Ports: clk, rst (sync, active high), push/push_idx/push_taken,
//          pop, full, empty, head_idx/head_taken (oldest entry).
//   full/empty come straight from the registered occupancy count.
module bht_upd_fifo #(
    parameter int IDX_W = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             push_taken,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [IDX_W-1:0] head_idx,
    output logic             head_taken
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W:0]   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign {head_idx, head_taken} = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap on their own.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {push_idx, push_taken};
        end
    end

endmodule

// File: rtl/bht_port_sched.sv
// bht_port_sched
//   Sole master of the single-port 2-bit branch history table. After reset it
//   sweeps every entry to INIT_CTR, then shares the port between fetch
//   lookups and queued resolved-branch updates (read, capture, write back a
//   saturated counter).
//   Ports: clk, rst (sync, active high), bus (bht_port_sched_if.slave):
//     predict channel, resolve channel, table port, init_done.
module bht_port_sched
    import bht_pkg::*;
#(
    parameter int   IDX_W      = 2,
    parameter int   UPD_DEPTH  = 4,
    parameter int   STARVE_MAX = 8,
    parameter ctr_t INIT_CTR   = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    bht_port_sched_if.slave   bus
);

    localparam int ENTRIES  = 2 ** IDX_W;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    localparam logic [2:0] ST_INIT = SCHED_INIT;
    localparam logic [2:0] ST_IDLE = SCHED_IDLE;
    localparam logic [2:0] ST_RD   = SCHED_RD;
    localparam logic [2:0] ST_CAP  = SCHED_CAP;
    localparam logic [2:0] ST_WR   = SCHED_WR;

    logic [2:0]          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                init_done_q, init_done_d;
    logic                pred_valid_q, pred_valid_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    ctr_t                ctr_q, ctr_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [IDX_W-1:0]    head_idx;
    logic                head_taken;

    logic                upd_needs_port;
    logic                starve_force;
    logic                pred_grant;
    logic                upd_grant;

    bht_upd_fifo #(
        .IDX_W (IDX_W),
        .DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_idx   (bus.res_idx),
        .push_taken (bus.res_taken),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_idx   (head_idx),
        .head_taken (head_taken)
    );

    // Arbitration: predict owns the port unless an update has been denied
    // STARVE_MAX times in a row. Everything is gated by rst so an in-flight
    // access is dropped in the very cycle reset is asserted.
    always_comb begin
        upd_needs_port = (state_q == ST_RD) || (state_q == ST_WR);
        starve_force   = upd_needs_port && (starve_q == STARVE_W'(STARVE_MAX));
        bus.pred_ready = !rst && init_done_q && !starve_force;
        pred_grant     = bus.pred_req && bus.pred_ready;
        upd_grant      = !rst && upd_needs_port && !pred_grant;
        bus.res_ready  = !rst && init_done_q && !fifo_full;
        fifo_push      = bus.res_valid && bus.res_ready;
        fifo_pop       = (state_q == ST_WR) && upd_grant;
    end

    // Table port mux: init sweep, then predict read, then update read/write.
    always_comb begin
        bus.tbl_en    = 1'b0;
        bus.tbl_we    = 1'b0;
        bus.tbl_addr  = '0;
        bus.tbl_wdata = '0;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                bus.tbl_en    = 1'b1;
                bus.tbl_we    = 1'b1;
                bus.tbl_addr  = ptr_q;
                bus.tbl_wdata = INIT_CTR;
            end else if (pred_grant) begin
                bus.tbl_en   = 1'b1;
                bus.tbl_addr = bus.pred_idx;
            end else if (upd_grant) begin
                bus.tbl_en   = 1'b1;
                bus.tbl_addr = head_idx;
                if (state_q == ST_WR) begin
                    bus.tbl_we    = 1'b1;
                    bus.tbl_wdata = ctr_sat(ctr_q, head_taken);
                end
            end
        end
    end

    // The table read data is registered, so both the prediction result and
    // the update capture use tbl_rdata one cycle after their read.
    always_comb begin
        bus.pred_valid = pred_valid_q;
        bus.pred_ctr   = pred_valid_q ? bus.tbl_rdata : CTR_SNT;
        bus.pred_taken = bus.pred_ctr[1];
        bus.init_done  = init_done_q;
    end

    // Sweep / update sequencing. The FIFO head is only popped on the write,
    // so an update to the same index as the next one is always written back
    // before the next one reads.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        init_done_d  = init_done_q;
        ctr_d        = ctr_q;
        starve_d     = starve_q;
        pred_valid_d = pred_grant;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == IDX_W'(ENTRIES - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (upd_grant) begin
                    state_d = ST_CAP;
                end
            end
            ST_CAP: begin
                ctr_d   = bus.tbl_rdata;
                state_d = ST_WR;
            end
            ST_WR: begin
                if (upd_grant) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        if (upd_needs_port) begin
            if (upd_grant) begin
                starve_d = '0;
            end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            init_done_q  <= 1'b0;
            pred_valid_q <= 1'b0;
            starve_q     <= '0;
            ctr_q        <= CTR_SNT;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            init_done_q  <= init_done_d;
            pred_valid_q <= pred_valid_d;
            starve_q     <= starve_d;
            ctr_q        <= ctr_d;
        end
    end

endmodule

// File: tb/tb_bht_port_sched.sv
// tb_bht_port_sched
//   Drives random and directed predict/resolve traffic into bht_port_sched,
//   emulates the registered-read table, and checks every observable against
//   a reference model built from counters-per-index plus an ordered queue of
//   accepted outcomes.
module tb_bht_port_sched;
    import bht_pkg::*;

    localparam int         IDX_W      = 2;
    localparam int         ENTRIES    = 4;
    localparam int         UPD_DEPTH  = 4;
    localparam int         STARVE_MAX = 8;
    localparam logic [1:0] INIT_CTR   = 2'b11;

    typedef struct {
        int idx;
        bit taken;
    } upd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bht_port_sched_if #(.IDX_W(IDX_W)) bus ();

    bht_port_sched #(
        .IDX_W      (IDX_W),
        .UPD_DEPTH  (UPD_DEPTH),
        .STARVE_MAX (STARVE_MAX),
        .INIT_CTR   (INIT_CTR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [1:0] ref_tbl [ENTRIES];
    upd_t       exp_q [$];
    bit         pend_pred;
    logic [1:0] pend_exp;
    int         rel_cycle;
    int         cyc;
    int         push_cnt;
    int         upd_wr_cnt;
    int         last_push_cyc;
    int         last_wr_cyc;
    int         force_q [$];
    logic [3:0] force_info_q [$];

    // Bench-side table: one access per cycle, read data registered.
    logic [1:0] tbl_mem [ENTRIES];

    always @(posedge clk) begin
        if (bus.tbl_en) begin
            if (bus.tbl_we) begin
                tbl_mem[bus.tbl_addr] <= bus.tbl_wdata;
            end else begin
                bus.tbl_rdata <= tbl_mem[bus.tbl_addr];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Counter step computed as clamped integer arithmetic.
    function automatic logic [1:0] modelStep(input logic [1:0] c, input bit taken);
        int v;
        v = int'(c) + (taken ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction

    // Monitor: sample the cycle at the falling edge, compare against the
    // model, then advance the model by this cycle's handshakes.
    always @(negedge clk) begin : monitor
        upd_t       u;
        logic [1:0] nv;
        bit         exp_init;
        cyc++;
        if (rst) begin
            checkOutput("rst_tbl_idle", 32'(bus.tbl_en), 32'd0);
            rel_cycle = 0;
            pend_pred = 1'b0;
            exp_q.delete();
            for (int i = 0; i < ENTRIES; i++) ref_tbl[i] = INIT_CTR;
        end else begin
            rel_cycle++;
            exp_init = (rel_cycle > ENTRIES);
            checkOutput("init_done", 32'(bus.init_done), 32'(exp_init));
            checkOutput("res_ready", 32'(bus.res_ready),
                        32'(exp_init && (exp_q.size() < UPD_DEPTH)));
            if (!exp_init) begin
                checkOutput("pred_ready_init", 32'(bus.pred_ready), 32'd0);
                checkOutput("init_write", 32'({bus.tbl_en, bus.tbl_we}), 32'd3);
                checkOutput("init_addr", 32'(bus.tbl_addr), 32'(rel_cycle - 1));
                checkOutput("init_data", 32'(bus.tbl_wdata), 32'(INIT_CTR));
            end
            checkOutput("pred_valid", 32'(bus.pred_valid), 32'(pend_pred));
            if (pend_pred) begin
                checkOutput("pred_ctr", 32'(bus.pred_ctr), 32'(pend_exp));
                checkOutput("pred_taken", 32'(bus.pred_taken), 32'(pend_exp[1]));
            end else begin
                checkOutput("pred_ctr_idle", 32'(bus.pred_ctr), 32'd0);
            end
            pend_pred = 1'b0;
            if (bus.pred_req && bus.pred_ready) begin
                checkOutput("pred_port", 32'({bus.tbl_en, bus.tbl_we, bus.tbl_addr}),
                            32'({1'b1, 1'b0, bus.pred_idx}));
                pend_pred = 1'b1;
                pend_exp  = ref_tbl[bus.pred_idx];
            end
            if (bus.init_done && bus.pred_req && !bus.pred_ready) begin
                force_q.push_back(cyc);
                force_info_q.push_back({bus.tbl_en, bus.tbl_we, bus.tbl_addr});
            end
            if (exp_init && bus.tbl_en && bus.tbl_we) begin
                checkOutput("upd_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    u  = exp_q.pop_front();
                    nv = modelStep(ref_tbl[u.idx], u.taken);
                    checkOutput("upd_addr", 32'(bus.tbl_addr), 32'(u.idx));
                    checkOutput("upd_data", 32'(bus.tbl_wdata), 32'(nv));
                    ref_tbl[u.idx] = nv;
                    upd_wr_cnt++;
                    last_wr_cyc = cyc;
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                u.idx   = int'(bus.res_idx);
                u.taken = bus.res_taken;
                exp_q.push_back(u);
                push_cnt++;
                last_push_cyc = cyc;
            end
        end
    end

    task automatic applyStimulus(input logic preq, input logic [1:0] pidx,
                                 input logic rv, input logic [1:0] ridx, input logic rt);
        @(posedge clk);
        #1;
        bus.pred_req  = preq;
        bus.pred_idx  = pidx;
        bus.res_valid = rv;
        bus.res_idx   = ridx;
        bus.res_taken = rt;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    endtask

    // Bounded wait for the model queue to empty; optionally keep fetch busy.
    task automatic waitDrain(input int budget, input bit keep_pred);
        int n;
        n = 0;
        applyStimulus(keep_pred, 2'($urandom_range(0, 3)), 1'b0, 2'd0, 1'b0);
        while (exp_q.size() != 0 && n < budget) begin
            applyStimulus(keep_pred, 2'($urandom_range(0, 3)), 1'b0, 2'd0, 1'b0);
            n++;
        end
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
        idleCycles(3);
    endtask

    task automatic checkPredict(input string tag, input logic [1:0] idx, input logic [1:0] exp_ctr);
        applyStimulus(1'b1, idx, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 32'(bus.pred_valid), 32'd1);
        checkOutput({tag, "_ctr"}, 32'(bus.pred_ctr), 32'(exp_ctr));
        checkOutput({tag, "_taken"}, 32'(bus.pred_taken), 32'(exp_ctr[1]));
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        int snap;
        int diff;
        bus.pred_req  = 1'b0;
        bus.pred_idx  = '0;
        bus.res_valid = 1'b0;
        bus.res_idx   = '0;
        bus.res_taken = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: init sweep (checked cycle by cycle in the monitor)
        idleCycles(6);
        checkOutput("t1_init_done", 32'(bus.init_done), 32'd1);

        // 2: first lookup after init sees the sweep value
        checkPredict("t2_pred", 2'd2, 2'b11);

        // 3: not-taken steps down and saturates at 00
        applyStimulus(1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
        waitDrain(50, 1'b0);
        checkOutput("t3_tbl2_01", 32'(tbl_mem[2]), 32'd1);
        checkPredict("t3_pred01", 2'd2, 2'b01);
        repeat (3) applyStimulus(1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
        waitDrain(50, 1'b0);
        checkOutput("t3_tbl2_00", 32'(tbl_mem[2]), 32'd0);
        checkPredict("t3_pred00", 2'd2, 2'b00);

        // 4: starvation forces the update through under continuous predict
        force_q.delete();
        force_info_q.delete();
        applyStimulus(1'b1, 2'($urandom_range(0, 3)), 1'b1, 2'd1, 1'b1);
        repeat (25) applyStimulus(1'b1, 2'($urandom_range(0, 3)), 1'b0, 2'd0, 1'b0);
        idleCycles(1);
        checkOutput("t4_forced_cycles", 32'(force_q.size()), 32'd2);
        if (force_q.size() >= 2) begin
            checkOutput("t4_first_force", 32'(force_q[0] - last_push_cyc), 32'(STARVE_MAX + 2));
            checkOutput("t4_force_gap", 32'(force_q[1] - force_q[0]), 32'(STARVE_MAX + 2));
            checkOutput("t4_rd_access", 32'(force_info_q[0]), 32'(4'b1001));
            checkOutput("t4_wr_access", 32'(force_info_q[1]), 32'(4'b1101));
        end
        diff = last_wr_cyc - last_push_cyc;
        checkOutput("t4_latency_ok", 32'(diff > 0 && diff <= 2 * (STARVE_MAX + 1) + 2), 32'd1);
        waitDrain(50, 1'b0);
        checkOutput("t4_tbl1", 32'(tbl_mem[1]), 32'd3);

        // 5: five back-to-back outcomes under predict pressure, only four fit
        snap = push_cnt;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'($urandom_range(0, 3)), 1'b1,
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        checkOutput("t5_res_ready_full", 32'(bus.res_ready), 32'd0);
        waitDrain(300, 1'b1);
        checkOutput("t5_accepted", 32'(push_cnt - snap), 32'd4);
        for (int i = 0; i < ENTRIES; i++) begin
            checkOutput("t5_tbl", 32'(tbl_mem[i]), 32'(ref_tbl[i]));
        end

        // Random mixed traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
        end
        waitDrain(400, 1'b0);
        for (int i = 0; i < ENTRIES; i++) begin
            checkOutput("rand_tbl", 32'(tbl_mem[i]), 32'(ref_tbl[i]));
        end

        // 6: reset during the first write-back with three more queued
        snap = upd_wr_cnt;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 2'd0, 1'b1, 2'(i), 1'b0);
        end
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.res_valid = 1'b0;
        @(negedge clk);
        checkOutput("t6_no_access", 32'(bus.tbl_en), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idleCycles(12);
        checkOutput("t6_no_upd_write", 32'(upd_wr_cnt - snap), 32'd0);
        checkOutput("t6_res_ready", 32'(bus.res_ready), 32'd1);
        for (int i = 0; i < ENTRIES; i++) begin
            checkOutput("t6_tbl", 32'(tbl_mem[i]), 32'(INIT_CTR));
            checkPredict("t6_pred", 2'(i), INIT_CTR);
        end
        idleCycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
